// File: rtl/i2c_hub_arb.sv
// N-port I2C hub: the first upstream master to issue a START owns the
// downstream pads until STOP; includes input filtering and stuck-bus recovery.
module i2c_hub_arb #(
    parameter int N_UP        = 5,
    parameter int FILT_LEN    = 3,
    parameter int TIMEOUT_CYC = 100000,
    localparam int OW = (N_UP > 1) ? $clog2(N_UP) : 1,
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_UP-1:0] up_en,
    input  logic [N_UP-1:0] up_scl_t,
    input  logic [N_UP-1:0] up_sda_t,
    input  logic [N_UP-1:0] up_scl_i,
    input  logic [N_UP-1:0] up_sda_i,
    output logic [N_UP-1:0] up_scl_o,
    output logic [N_UP-1:0] up_sda_o,
    output logic            dn_scl_t,
    output logic            dn_sda_t,
    output logic            dn_scl_o,
    output logic            dn_sda_o,
    input  logic            dn_scl_i,
    input  logic            dn_sda_i,
    output logic [OW-1:0]   owner,
    output logic            busy_up,
    output logic            busy_ext,
    output logic            timeout_stb,
    output logic [1:0]      fsm_state
);
    localparam int CW = $clog2(FILT_LEN + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, EXT = 2'd2, RECOVER = 2'd3} state_t;
    state_t state;

    // Line index 0 is SCL, 1 is SDA.
    logic [1:0]         sync1, sync2, filt, filt_nxt;
    logic [1:0][CW-1:0] fcnt, fcnt_nxt;
    logic               fscl, fsda, fscl_q, fsda_q;
    logic               start_ev, stop_ev, scl_edge;

    always_comb begin
        filt_nxt = filt;
        fcnt_nxt = '0;
        for (int l = 0; l < 2; l++) begin
            if (sync2[l] != filt[l]) begin
                if (fcnt[l] == CW'(FILT_LEN - 1)) filt_nxt[l] = sync2[l];
                else fcnt_nxt[l] = fcnt[l] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            fcnt   <= '0;
            fscl_q <= 1'b1;
            fsda_q <= 1'b1;
        end else begin
            sync1  <= {dn_sda_i, dn_scl_i};
            sync2  <= sync1;
            filt   <= filt_nxt;
            fcnt   <= fcnt_nxt;
            fscl_q <= filt[0];
            fsda_q <= filt[1];
        end
    end

    assign fscl     = filt[0];
    assign fsda     = filt[1];
    assign start_ev = fscl_q & fscl & fsda_q & ~fsda;
    assign stop_ev  = fscl_q & fscl & ~fsda_q & fsda;
    // Edge seen at the filter update so the count restarts on the same clock.
    assign scl_edge = filt_nxt[0] != filt[0];

    assign up_scl_o  = {N_UP{fscl}};
    assign up_sda_o  = {N_UP{fsda}};
    assign dn_scl_o  = 1'b0;
    assign dn_sda_o  = 1'b0;
    assign fsm_state = state;

    // Open-drain decode: only t=0 with i=0 pulls the line low.
    logic [N_UP-1:0] scl_drv, sda_drv, req;
    logic            req_any;
    logic [OW-1:0]   req_idx;

    assign scl_drv = ~up_scl_t & ~up_scl_i;
    assign sda_drv = ~up_sda_t & ~up_sda_i;
    assign req     = up_en & sda_drv & ~scl_drv;

    always_comb begin
        req_any = 1'b0;
        req_idx = '0;
        for (int k = N_UP - 1; k >= 0; k--) begin
            if (req[k]) begin
                req_any = 1'b1;
                req_idx = OW'(k);
            end
        end
    end

    // After reset no grant until the filtered bus has read idle long enough.
    logic          armed;
    logic [CW-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            hold_cnt <= '0;
        end else if (!armed) begin
            if (fscl && fsda) begin
                if (hold_cnt == CW'(FILT_LEN - 1)) armed <= 1'b1;
                else hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          counting;

    assign counting = (state == OWN) || (state == EXT);
    assign to_hit   = (TIMEOUT_CYC != 0) && (to_cnt == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            busy_up     <= 1'b0;
            busy_ext    <= 1'b0;
            dn_scl_t    <= 1'b1;
            dn_sda_t    <= 1'b1;
            timeout_stb <= 1'b0;
            to_cnt      <= '0;
        end else begin
            timeout_stb <= 1'b0;
            if (scl_edge || !counting) to_cnt <= '0;
            else if (to_cnt != {TW{1'b1}}) to_cnt <= to_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (start_ev) begin
                        state    <= EXT;
                        busy_ext <= 1'b1;
                    end else if (armed && req_any && fscl && fsda) begin
                        state    <= OWN;
                        owner    <= req_idx;
                        busy_up  <= 1'b1;
                        dn_scl_t <= 1'b1;
                        dn_sda_t <= 1'b0;
                    end
                end
                OWN: begin
                    if (to_hit) begin
                        state       <= RECOVER;
                        busy_up     <= 1'b0;
                        dn_scl_t    <= 1'b1;
                        dn_sda_t    <= 1'b1;
                        timeout_stb <= 1'b1;
                    end else if (stop_ev) begin
                        state    <= IDLE;
                        busy_up  <= 1'b0;
                        dn_scl_t <= 1'b1;
                        dn_sda_t <= 1'b1;
                    end else begin
                        dn_scl_t <= ~scl_drv[owner];
                        dn_sda_t <= ~sda_drv[owner];
                    end
                end
                EXT: begin
                    if (to_hit) begin
                        state       <= RECOVER;
                        busy_ext    <= 1'b0;
                        timeout_stb <= 1'b1;
                    end else if (stop_ev) begin
                        state    <= IDLE;
                        busy_ext <= 1'b0;
                    end
                end
                RECOVER: begin
                    if (fscl && fsda && !(|(up_en & (scl_drv | sda_drv)))) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_hub_arb.sv
// Bench for i2c_hub_arb: a vector table for owner forwarding plus hand-written
// sequences for arbitration, filtering, external master, timeout and reset.
module tb_i2c_hub_arb;
    localparam int N  = 5;
    localparam int FL = 3;
    localparam int TO = 50;
    localparam logic [1:0] S_IDLE = 2'd0, S_OWN = 2'd1, S_EXT = 2'd2, S_REC = 2'd3;
    // Port drive nibble {scl_t, scl_i, sda_t, sda_i}.
    localparam logic [3:0] REL = 4'b1111, REQ = 4'b1100, LOWB = 4'b0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] up_en = '1, up_scl_t = '1, up_sda_t = '1, up_scl_i = '1, up_sda_i = '1;
    logic [N-1:0] up_scl_o, up_sda_o;
    logic         dn_scl_t, dn_sda_t, dn_scl_o, dn_sda_o, dn_scl_i, dn_sda_i;
    logic [2:0]   owner;
    logic         busy_up, busy_ext, timeout_stb;
    logic [1:0]   fsm_state;
    logic         ext_scl = 1'b1, ext_sda = 1'b1;

    // Wired-AND pad model: hub and external master can each pull low.
    assign dn_scl_i = dn_scl_t & ext_scl;
    assign dn_sda_i = dn_sda_t & ext_sda;

    i2c_hub_arb #(.N_UP(N), .FILT_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .up_en(up_en),
        .up_scl_t(up_scl_t), .up_sda_t(up_sda_t), .up_scl_i(up_scl_i), .up_sda_i(up_sda_i),
        .up_scl_o(up_scl_o), .up_sda_o(up_sda_o),
        .dn_scl_t(dn_scl_t), .dn_sda_t(dn_sda_t), .dn_scl_o(dn_scl_o), .dn_sda_o(dn_sda_o),
        .dn_scl_i(dn_scl_i), .dn_sda_i(dn_sda_i),
        .owner(owner), .busy_up(busy_up), .busy_ext(busy_ext),
        .timeout_stb(timeout_stb), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [7:0] mk(input logic bu, input logic be, input logic [2:0] ow,
                                      input logic st, input logic sdt, input logic stb);
        return {bu, be, ow, st, sdt, stb};
    endfunction

    // Owner is only meaningful while busy_up is set.
    function automatic logic [7:0] obs();
        return {busy_up, busy_ext, (busy_up ? owner : 3'd0), dn_scl_t, dn_sda_t, timeout_stb};
    endfunction

    task automatic expect_v(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string name);
        logic [7:0] e, a;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: no expected value queued", name);
            return;
        end
        e = exp_q.pop_front();
        a = obs();
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got {bu,be,own,sclt,sdat,stb}=%b expected %b", name, a, e);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int k, input logic [3:0] d);
        up_scl_t[k] = d[3];
        up_scl_i[k] = d[2];
        up_sda_t[k] = d[1];
        up_sda_i[k] = d[0];
    endtask

    task automatic wait_state(input string name, input logic [1:0] target, input int budget);
        int i;
        i = 0;
        while (fsm_state !== target && i < budget) begin
            step();
            i++;
        end
        n_checks++;
        if (fsm_state !== target) begin
            n_errors++;
            $display("FAIL %s: state %0d expected %0d within %0d cycles", name, fsm_state, target, budget);
        end
    endtask

    task automatic ext_hold(input int n);
        for (int i = 0; i < n; i++) begin
            expect_v(mk(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0));
            step();
            check("ext_hold");
        end
    endtask

    typedef struct packed {
        logic [3:0] own;
        logic [1:0] noise;
        logic       exp_scl_t;
        logic       exp_sda_t;
    } vec_t;
    vec_t tbl [8];

    logic ok, found;
    int   fall_cyc, stb_cyc, stb_n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Owner (port 2) drive, port 4 noise {scl_low, sda_low}, expected pads.
        tbl[0] = '{4'b0000, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{4'b0001, 2'b01, 1'b0, 1'b1};
        tbl[2] = '{4'b0101, 2'b10, 1'b1, 1'b1};
        tbl[3] = '{4'b0010, 2'b11, 1'b0, 1'b1};
        tbl[4] = '{4'b0000, 2'b00, 1'b0, 1'b0};
        tbl[5] = '{4'b1100, 2'b00, 1'b1, 1'b0};
        tbl[6] = '{4'b0000, 2'b11, 1'b0, 1'b0};
        tbl[7] = '{4'b1000, 2'b00, 1'b1, 1'b0};

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        expect_v(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0));
        check("reset_outputs");
        chk("reset_up_o", {up_scl_o, up_sda_o}, 10'h3FF);
        chk("reset_dn_o", {dn_scl_o, dn_sda_o}, 2'b00);
        chk("reset_state", fsm_state, S_IDLE);
        rst_n = 1'b1;
        repeat (6) step();

        // ---- glitch filter ----
        ext_scl = 1'b0;
        step();
        step();
        ext_scl = 1'b1;
        ok = 1'b1;
        repeat (8) begin
            step();
            if (up_scl_o !== 5'b11111) ok = 1'b0;
        end
        chk("glitch_2cyc_blocked", ok, 1);
        ext_scl = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i < 5) chk("pulse3_not_yet", up_scl_o, 5'b11111);
            else chk("pulse3_seen", up_scl_o, 5'b00000);
            if (i == 3) ext_scl = 1'b1;
        end
        repeat (6) step();
        chk("pulse3_recovered", up_scl_o, 5'b11111);

        // ---- basic transaction, port 2, vector table ----
        drive_port(2, REQ);
        expect_v(mk(1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0));
        step();
        check("basic_grant");
        for (int r = 0; r < 8; r++) begin
            drive_port(2, tbl[r].own);
            drive_port(4, {~tbl[r].noise[1], ~tbl[r].noise[1], ~tbl[r].noise[0], ~tbl[r].noise[0]});
            expect_v(mk(1'b1, 1'b0, 3'd2, tbl[r].exp_scl_t, tbl[r].exp_sda_t, 1'b0));
            step();
            check($sformatf("row%0d", r));
            repeat (3) step();
        end
        drive_port(2, REL);
        expect_v(mk(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0));
        step();
        check("stop_forward");
        repeat (4) step();
        expect_v(mk(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0));
        step();
        check("stop_pending");
        expect_v(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0));
        step();
        check("stop_release");
        repeat (4) step();

        // ---- simultaneous requests, ports 1 and 3 ----
        drive_port(1, REQ);
        drive_port(3, REQ);
        expect_v(mk(1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0));
        step();
        check("simul_grant_low");
        drive_port(3, LOWB);
        for (int i = 0; i < 6; i++) begin
            expect_v(mk(1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0));
            step();
            check("simul_isolate");
        end
        chk("simul_port3_sees_sda", up_sda_o[3], 1'b0);
        chk("simul_port3_sees_scl", up_scl_o[3], 1'b1);
        drive_port(3, 4'b1111);
        drive_port(3, 4'b0011);
        expect_v(mk(1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0));
        step();
        check("simul_isolate_sda_rel");
        drive_port(3, REL);
        drive_port(1, LOWB);
        repeat (4) step();
        drive_port(1, REQ);
        repeat (4) step();
        drive_port(1, REL);
        wait_state("simul_stop", S_IDLE, 15);
        repeat (3) step();

        // ---- external master START colliding with port 0 request ----
        ext_sda = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (up_sda_o[0] === 1'b0) found = 1'b1;
        end
        chk("ext_start_filtered", found, 1'b1);
        drive_port(0, REQ);
        expect_v(mk(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0));
        step();
        check("ext_wins");
        chk("ext_state", fsm_state, S_EXT);
        ext_scl = 1'b0;
        ext_hold(4);
        ext_sda = 1'b1;
        ext_hold(4);
        ext_scl = 1'b1;
        ext_hold(8);
        ext_scl = 1'b0;
        ext_hold(4);
        ext_sda = 1'b0;
        ext_hold(4);
        ext_scl = 1'b1;
        ext_hold(4);
        drive_port(0, REL);
        ext_sda = 1'b1;
        wait_state("ext_stop", S_IDLE, 15);
        expect_v(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0));
        check("ext_released");
        drive_port(0, REQ);
        expect_v(mk(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0));
        step();
        check("port0_after_ext");
        repeat (8) step();
        drive_port(0, REL);
        wait_state("port0_stop", S_IDLE, 15);
        repeat (3) step();

        // ---- stuck owner, timeout and recovery ----
        drive_port(4, REQ);
        expect_v(mk(1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0));
        step();
        check("stuck_grant");
        repeat (3) step();
        drive_port(4, LOWB);
        fall_cyc = -1;
        stb_cyc = -1;
        stb_n = 0;
        for (int i = 0; i < 68; i++) begin
            step();
            if (fall_cyc < 0 && up_scl_o[0] === 1'b0) fall_cyc = cyc;
            if (timeout_stb === 1'b1) begin
                stb_n++;
                if (stb_cyc < 0) begin
                    stb_cyc = cyc;
                    expect_v(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1));
                    check("timeout_release");
                    chk("timeout_state", fsm_state, S_REC);
                end
            end
        end
        chk("timeout_pulses", stb_n, 1);
        chk("timeout_delay", stb_cyc - fall_cyc, 51);
        chk("recover_held_by_port", fsm_state, S_REC);
        drive_port(4, REL);
        wait_state("recover_exit", S_IDLE, 10);
        repeat (3) step();

        // ---- reset mid-transaction ----
        drive_port(2, REQ);
        expect_v(mk(1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0));
        step();
        check("pre_reset_grant");
        repeat (2) step();
        drive_port(2, LOWB);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        expect_v(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0));
        check("async_reset_release");
        chk("async_reset_state", fsm_state, S_IDLE);
        drive_port(2, REQ);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= FL + 1; i++) begin
            if (i <= FL) expect_v(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0));
            else expect_v(mk(1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0));
            step();
            check($sformatf("post_reset_cycle%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
